// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

    localparam int BRU_DEPTH  = 4;
    localparam int BRU_GHR_W  = 12;
    localparam int BRU_ADDR_W = 32;

    // Sequential PC after a branch skips the branch and its delay slot.
    localparam int unsigned DELAY_SLOT_OFFSET = 8;

    // Default-width layout of one in-flight prediction; the top builds the
    // same field order at its own parameter widths.
    typedef struct packed {
        logic [BRU_ADDR_W-1:0] addr;
        logic                  taken;
        logic [BRU_ADDR_W-1:0] target;
        logic [BRU_GHR_W-1:0]  ghr;
    } bru_entry_t;

    function automatic int bru_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// Circular FIFO with extra-MSB pointers, synchronous clear and
// combinational head read. The caller only pushes when a slot is free.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = bru_ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign rdata = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // When full, a simultaneous pop frees the slot being written.
            if (push) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches fetch-time predictions against EX outcomes in order; drives predictor
// training, mispredict flush/redirect and GHR restore. BRU_STATS_EN adds counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH  = BRU_DEPTH,
    parameter int GHR_W  = BRU_GHR_W,
    parameter int ADDR_W = BRU_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              Pred_valid,
    output logic              Pred_ready,
    input  logic [ADDR_W-1:0] Pred_addr,
    input  logic              Pred_taken,
    input  logic [ADDR_W-1:0] Pred_target,
    input  logic [GHR_W-1:0]  Pred_ghr,
    input  logic              Res_valid,
    input  logic              Res_taken,
    input  logic [ADDR_W-1:0] Res_target,
    output logic              Upd_valid,
    output logic [ADDR_W-1:0] Upd_addr,
    output logic              Upd_taken,
    output logic [GHR_W-1:0]  Upd_ghr,
    output logic              Mispredict,
    output logic [ADDR_W-1:0] Redirect_addr,
    output logic [GHR_W-1:0]  Ghr_restore,
    output logic              Res_error
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       Branch_count,
    output logic [31:0]       Mispredict_count
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [GHR_W-1:0]  ghr;
    } entry_t;

    entry_t push_entry;
    entry_t head;
    logic   fifo_full, fifo_empty;
    logic   do_push, do_pop, miss, clear;

    // Handshake: a prediction transfers on a cycle where Pred_valid and
    // Pred_ready are both high; Pred_ready never depends on Pred_valid.
    always_comb begin
        push_entry.addr   = Pred_addr;
        push_entry.taken  = Pred_taken;
        push_entry.target = Pred_target;
        push_entry.ghr    = Pred_ghr;

        do_pop     = Res_valid && !fifo_empty && !FLUSH;
        miss       = do_pop && ((Res_taken != head.taken) ||
                                (Res_taken && head.taken && (Res_target != head.target)));
        Pred_ready = !fifo_full || (Res_valid && !FLUSH);
        // Anything pushed alongside a mispredict is wrong-path.
        do_push    = Pred_valid && Pred_ready && !FLUSH && !miss;
        clear      = FLUSH || miss;
    end

    bru_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (do_push),
        .pop   (do_pop),
        .clear (clear),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    logic              upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
    logic              upd_taken_q, upd_taken_d;
    logic [GHR_W-1:0]  upd_ghr_q, upd_ghr_d;
    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [GHR_W-1:0]  ghr_restore_q, ghr_restore_d;
    logic              res_error_q, res_error_d;

    always_comb begin
        upd_valid_d   = do_pop;
        mispredict_d  = miss;
        res_error_d   = Res_valid && fifo_empty && !FLUSH;
        upd_addr_d    = upd_addr_q;
        upd_taken_d   = upd_taken_q;
        upd_ghr_d     = upd_ghr_q;
        ghr_restore_d = ghr_restore_q;
        redirect_d    = redirect_q;
        if (do_pop) begin
            upd_addr_d    = head.addr;
            upd_taken_d   = Res_taken;
            upd_ghr_d     = head.ghr;
            ghr_restore_d = {head.ghr[GHR_W-2:0], Res_taken};
        end
        if (miss) begin
            redirect_d = Res_taken ? Res_target
                                   : head.addr + ADDR_W'(DELAY_SLOT_OFFSET);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            upd_valid_q   <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            upd_ghr_q     <= '0;
            mispredict_q  <= 1'b0;
            redirect_q    <= '0;
            ghr_restore_q <= '0;
            res_error_q   <= 1'b0;
        end else begin
            upd_valid_q   <= upd_valid_d;
            upd_addr_q    <= upd_addr_d;
            upd_taken_q   <= upd_taken_d;
            upd_ghr_q     <= upd_ghr_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
            ghr_restore_q <= ghr_restore_d;
            res_error_q   <= res_error_d;
        end
    end

    assign Upd_valid     = upd_valid_q;
    assign Upd_addr      = upd_addr_q;
    assign Upd_taken     = upd_taken_q;
    assign Upd_ghr       = upd_ghr_q;
    assign Mispredict    = mispredict_q;
    assign Redirect_addr = redirect_q;
    assign Ghr_restore   = ghr_restore_q;
    assign Res_error     = res_error_q;

`ifdef BRU_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Saturating counters; only RESET clears them.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (do_pop && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (miss && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign Branch_count     = branch_count_q;
    assign Mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_resolve_unit;

    localparam int DEPTH  = 4;
    localparam int GHR_W  = 12;
    localparam int ADDR_W = 32;

    logic              CLK, RESET, FLUSH;
    logic              Pred_valid, Pred_ready, Pred_taken;
    logic [ADDR_W-1:0] Pred_addr, Pred_target;
    logic [GHR_W-1:0]  Pred_ghr;
    logic              Res_valid, Res_taken;
    logic [ADDR_W-1:0] Res_target;
    logic              Upd_valid, Upd_taken, Mispredict, Res_error;
    logic [ADDR_W-1:0] Upd_addr, Redirect_addr;
    logic [GHR_W-1:0]  Upd_ghr, Ghr_restore;
`ifdef BRU_STATS_EN
    logic [31:0]       Branch_count, Mispredict_count;
`endif

    branch_resolve_unit #(.DEPTH(DEPTH), .GHR_W(GHR_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .Pred_valid(Pred_valid), .Pred_ready(Pred_ready), .Pred_addr(Pred_addr),
        .Pred_taken(Pred_taken), .Pred_target(Pred_target), .Pred_ghr(Pred_ghr),
        .Res_valid(Res_valid), .Res_taken(Res_taken), .Res_target(Res_target),
        .Upd_valid(Upd_valid), .Upd_addr(Upd_addr), .Upd_taken(Upd_taken),
        .Upd_ghr(Upd_ghr), .Mispredict(Mispredict), .Redirect_addr(Redirect_addr),
        .Ghr_restore(Ghr_restore), .Res_error(Res_error)
`ifdef BRU_STATS_EN
        , .Branch_count(Branch_count), .Mispredict_count(Mispredict_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic [31:0] target;
        logic [11:0] ghr;
    } ent_t;

    ent_t        mq[$];
    logic        e_upd_valid, e_upd_taken, e_mp, e_err;
    logic [31:0] e_upd_addr, e_redirect;
    logic [11:0] e_upd_ghr, e_restore;
    longint      e_bcnt, e_mcnt;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per clock edge, cleared on reset.
    initial begin : model
        int   sz;
        bit   ready, mp;
        ent_t h, n;
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                mq.delete();
                e_upd_valid = 0; e_upd_taken = 0; e_mp = 0; e_err = 0;
                e_upd_addr = 0; e_redirect = 0; e_upd_ghr = 0; e_restore = 0;
                e_bcnt = 0; e_mcnt = 0;
            end else begin
                sz = mq.size();
                ready = (sz < DEPTH) || (Res_valid && !FLUSH);
                mp = 0;
                e_upd_valid = 0; e_mp = 0; e_err = 0;
                if (FLUSH) begin
                    mq.delete();
                end else begin
                    if (Res_valid) begin
                        if (sz == 0) begin
                            e_err = 1;
                        end else begin
                            h = mq.pop_front();
                            e_upd_valid = 1;
                            e_upd_addr  = h.addr;
                            e_upd_taken = Res_taken;
                            e_upd_ghr   = h.ghr;
                            e_restore   = 12'((int'(h.ghr) * 2 + int'(Res_taken)) % 4096);
                            mp = (Res_taken != h.taken) || (Res_taken && Res_target != h.target);
                            if (e_bcnt < 64'hFFFF_FFFF) e_bcnt++;
                            if (mp) begin
                                e_mp = 1;
                                e_redirect = Res_taken ? Res_target : h.addr + 32'd8;
                                mq.delete();
                                if (e_mcnt < 64'hFFFF_FFFF) e_mcnt++;
                            end
                        end
                    end
                    if (Pred_valid && ready && !mp) begin
                        n.addr = Pred_addr; n.taken = Pred_taken;
                        n.target = Pred_target; n.ghr = Pred_ghr;
                        mq.push_back(n);
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin : compare
        logic exp_ready;
        forever begin
            @(negedge CLK);
            #2;
            if (chk_en) begin
                exp_ready = RESET || (mq.size() < DEPTH) || (Res_valid && !FLUSH);
                cmp("pred_ready", Pred_ready, exp_ready);
                cmp("upd_valid", Upd_valid, e_upd_valid);
                cmp("mispredict", Mispredict, e_mp);
                cmp("res_error", Res_error, e_err);
                if (e_upd_valid) begin
                    cmp("upd_addr", Upd_addr, e_upd_addr);
                    cmp("upd_taken", Upd_taken, e_upd_taken);
                    cmp("upd_ghr", Upd_ghr, e_upd_ghr);
                    cmp("ghr_restore", Ghr_restore, e_restore);
                end
                if (e_mp) cmp("redirect", Redirect_addr, e_redirect);
`ifdef BRU_STATS_EN
                cmp("branch_count", Branch_count, 32'(e_bcnt));
                cmp("mispredict_count", Mispredict_count, 32'(e_mcnt));
`endif
            end
        end
    end

    task automatic drive(input logic pv, input logic [31:0] pa, input logic pt,
                         input logic [31:0] ptg, input logic [11:0] pg, input logic rv,
                         input logic rt, input logic [31:0] rtg, input logic fl);
        @(negedge CLK);
        Pred_valid = pv; Pred_addr = pa; Pred_taken = pt; Pred_target = ptg; Pred_ghr = pg;
        Res_valid = rv; Res_taken = rt; Res_target = rtg; FLUSH = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] a, input logic t, input logic [31:0] tg, input logic [11:0] g);
        drive(1, a, t, tg, g, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        drive(0, 0, 0, 0, 0, 1, t, tg, 0);
    endtask

    initial begin : main
        logic        rt;
        logic [31:0] rtg;
        RESET = 1;
        Pred_valid = 0; Pred_addr = 0; Pred_taken = 0; Pred_target = 0; Pred_ghr = 0;
        Res_valid = 0; Res_taken = 0; Res_target = 0; FLUSH = 0;
        repeat (2) @(negedge CLK);
        RESET = 0;
        chk_en = 1;
        idle(); #3;
        cmp("lit_reset_ready", Pred_ready, 1'b1);
        cmp("lit_reset_upd", Upd_valid, 1'b0);
        cmp("lit_reset_mp", Mispredict, 1'b0);
        cmp("lit_reset_err", Res_error, 1'b0);

        // Correct not-taken
        push(32'h0040_0100, 0, 0, 12'h0A5);
        resolve(0, 0);
        idle(); #3;
        cmp("lit_nt_upd", Upd_valid, 1'b1);
        cmp("lit_nt_addr", Upd_addr, 32'h0040_0100);
        cmp("lit_nt_ghr", Upd_ghr, 12'h0A5);
        cmp("lit_nt_restore", Ghr_restore, 12'h14A);
        cmp("lit_nt_mp", Mispredict, 1'b0);

        // Direction miss
        push(32'h0040_0200, 0, 0, 12'h123);
        resolve(1, 32'h0040_0800);
        idle(); #3;
        cmp("lit_dir_mp", Mispredict, 1'b1);
        cmp("lit_dir_redirect", Redirect_addr, 32'h0040_0800);
        cmp("lit_dir_upd", Upd_valid, 1'b1);

        // Not-taken resolution of a predicted-taken branch falls through past the delay slot
        push(32'h0040_0280, 1, 32'h0040_0900, 12'h004);
        resolve(0, 0);
        idle(); #3;
        cmp("lit_nt_redirect", Redirect_addr, 32'h0040_0288);

        // Target miss wipes younger entries
        push(32'h0040_0300, 1, 32'h0040_1000, 12'h001);
        push(32'h0040_0304, 0, 0, 12'h002);
        push(32'h0040_0308, 1, 32'h0040_0000, 12'h003);
        resolve(1, 32'h0040_2000);
        idle(); #3;
        cmp("lit_tgt_mp", Mispredict, 1'b1);
        cmp("lit_tgt_redirect", Redirect_addr, 32'h0040_2000);
        resolve(0, 0);
        idle(); #3;
        cmp("lit_tgt_empty_err", Res_error, 1'b1);
        cmp("lit_tgt_empty_upd", Upd_valid, 1'b0);

        // Full, then push+pop across the wrap
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 0, 0, 12'(i));
        idle(); #3;
        cmp("lit_full_ready", Pred_ready, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h1000 + 32'(4 * (k + 4)), 0, 0, 12'(k + 4), 1, 0, 0, 0);
            #3;
            if (k > 0) cmp("lit_wrap_addr", Upd_addr, 32'h1000 + 32'(4 * (k - 1)));
        end
        idle(); #3;
        cmp("lit_wrap_last", Upd_addr, 32'h1000 + 32'(4 * 9));
        idle(); #3;
        cmp("lit_wrap_still_full", Pred_ready, 1'b0);

        // FLUSH beats Res_valid
        drive(1, 32'h7777, 0, 0, 0, 1, 1, 32'h9999, 1);
        idle(); #3;
        cmp("lit_flush_upd", Upd_valid, 1'b0);
        cmp("lit_flush_mp", Mispredict, 1'b0);
        cmp("lit_flush_err", Res_error, 1'b0);
        resolve(0, 0);
        idle(); #3;
        cmp("lit_flush_empty_err", Res_error, 1'b1);

        // RESET mid-stream cancels a pending strobe and the remaining entry
        push(32'h2000, 0, 0, 12'h011);
        push(32'h2004, 0, 0, 12'h022);
        resolve(0, 0);
        @(negedge CLK);
        RESET = 1; Res_valid = 0;
        #3;
        cmp("lit_rst_upd", Upd_valid, 1'b0);
        cmp("lit_rst_ready", Pred_ready, 1'b1);
        @(negedge CLK);
        RESET = 0;
        resolve(0, 0);
        idle(); #3;
        cmp("lit_rst_empty_err", Res_error, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt = mq[0].taken; rtg = mq[0].target;
            end else begin
                rt = 1'($urandom_range(0, 1));
                rtg = $urandom_range(0, 1) ? 32'h8000 : 32'h8004;
            end
            drive(($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? 32'h8000 : 32'h8004, 12'($urandom),
                  ($urandom_range(0, 9) < 4), rt, rtg, ($urandom_range(0, 31) == 0));
            RESET = ($urandom_range(0, 199) == 0);
        end
        RESET = 0;
        repeat (3) idle();
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
